// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each requester hands over a command on valid/ready, and the block returns a tagged, registered response.
module alu_arbiter #(
    parameter int         Ancho  = 4,
    parameter logic [3:0] MAX_OP = 4'h9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [Ancho-1:0] req0_a,
    input  logic [Ancho-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req0_flagin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [Ancho-1:0] req1_a,
    input  logic [Ancho-1:0] req1_b,
    input  logic [3:0]       req1_op,
    input  logic             req1_flagin,
    output logic [Ancho-1:0] alu_a,
    output logic [Ancho-1:0] alu_b,
    output logic [3:0]       alu_control,
    output logic             alu_flagin,
    input  logic [Ancho-1:0] alu_result,
    input  logic             alu_flags,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [Ancho-1:0] rsp_result,
    output logic             rsp_flags,
    output logic             rsp_z,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             id;
    logic             grant_valid;
    logic             grant_sel;
    logic [Ancho-1:0] sel_a;
    logic [Ancho-1:0] sel_b;
    logic [3:0]       sel_op;
    logic             sel_flagin;
    logic             legal;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid && !grant_sel;
    assign req1_ready = grant_valid && grant_sel;

    assign sel_a      = grant_sel ? req1_a      : req0_a;
    assign sel_b      = grant_sel ? req1_b      : req0_b;
    assign sel_op     = grant_sel ? req1_op     : req0_op;
    assign sel_flagin = grant_sel ? req1_flagin : req0_flagin;
    assign legal      = (sel_op <= MAX_OP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = legal ? EXEC : RESP;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Illegal opcodes produce an error response straight away and never touch the ALU result path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            id          <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_flagin  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= 1'b0;
            rsp_z       <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        alu_control <= sel_op;
                        alu_flagin  <= sel_flagin;
                        id          <= grant_sel;
                        last_grant  <= grant_sel;
                        if (!legal) begin
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_flags  <= 1'b0;
                            rsp_z      <= 1'b0;
                            rsp_id     <= grant_sel;
                            rsp_valid  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_z      <= alu_z;
                    rsp_err    <= 1'b0;
                    rsp_id     <= id;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. A transaction-level model tracks the outstanding command and the last visible response.
// A behavioural ALU closes the loop on the DUT's ALU ports.
module tb_alu_arbiter;

    localparam int         W     = 4;
    localparam logic [3:0] MAXOP = 4'h9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_flagin;
    logic [W-1:0] req0_a, req0_b;
    logic [3:0]   req0_op;
    logic         req1_valid, req1_ready, req1_flagin;
    logic [W-1:0] req1_a, req1_b;
    logic [3:0]   req1_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_control;
    logic         alu_flagin, alu_flags, alu_z;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_flags, rsp_z, rsp_err;
    logic [W-1:0] rsp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.Ancho(W), .MAX_OP(MAXOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_flagin(req0_flagin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_flagin(req1_flagin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_flagin(alu_flagin),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    // Behavioural ALU: returns {zero, flag, result}.
    function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op, input logic fin);
        logic [W-1:0] r;
        logic         c;
        r = '0;
        c = 1'b0;
        case (op)
            4'h0: {c, r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, fin};
            4'h1: {c, r} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, fin};
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: {c, r} = {a, fin};
            4'h7: {r, c} = {fin, a};
            4'h8: r = a;
            4'h9: r = b;
            default: begin r = '1; c = 1'b1; end
        endcase
        return {(r == '0), c, r};
    endfunction

    logic [W+1:0] alu_out;
    assign alu_out    = alu_fn(alu_a, alu_b, alu_control, alu_flagin);
    assign alu_result = alu_out[W-1:0];
    assign alu_flags  = alu_out[W];
    assign alu_z      = alu_out[W+1];

    int vectors    = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         fl;
        logic         z;
        logic         err;
    } rsp_t;

    // Model state: one outstanding command at most, plus the response currently shown on rsp_*.
    bit           m_out;
    int           cyc = 0;
    int           rsp_at;
    logic         m_last, m_shown_valid;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_op;
    logic         m_fin;
    rsp_t         pend, shown;

    always @(posedge clk or negedge rst_n) begin
        logic         g;
        logic [W+1:0] o;
        if (!rst_n) begin
            m_out = 0; m_last = 1'b1; m_shown_valid = 1'b0;
            m_a = '0; m_b = '0; m_op = '0; m_fin = 1'b0;
            shown = '0; pend = '0; rsp_at = 0;
        end else begin
            if (m_out) begin
                if (cyc >= rsp_at && rsp_ready) m_out = 0;
            end else if (req0_valid || req1_valid) begin
                g     = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                m_a   = g ? req1_a : req0_a;
                m_b   = g ? req1_b : req0_b;
                m_op  = g ? req1_op : req0_op;
                m_fin = g ? req1_flagin : req0_flagin;
                m_last = g;
                if (m_op > MAXOP) begin
                    pend   = '{id: g, res: '0, fl: 1'b0, z: 1'b0, err: 1'b1};
                    rsp_at = cyc + 1;
                end else begin
                    o      = alu_fn(m_a, m_b, m_op, m_fin);
                    pend   = '{id: g, res: o[W-1:0], fl: o[W], z: o[W+1], err: 1'b0};
                    rsp_at = cyc + 2;
                end
                m_out = 1;
            end
            cyc++;
            m_shown_valid = m_out && (cyc >= rsp_at);
            if (m_shown_valid) shown = pend;
        end
    end

    always @(negedge clk) begin
        logic any_v, gsel;
        any_v = req0_valid || req1_valid;
        gsel  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        checkOutput("req0_ready", req0_ready, !m_out && any_v && !gsel);
        checkOutput("req1_ready", req1_ready, !m_out && any_v && gsel);
        checkOutput("alu_a", alu_a, m_a);
        checkOutput("alu_b", alu_b, m_b);
        checkOutput("alu_control", alu_control, m_op);
        checkOutput("alu_flagin", alu_flagin, m_fin);
        checkOutput("rsp_valid", rsp_valid, m_shown_valid);
        checkOutput("rsp_id", rsp_id, shown.id);
        checkOutput("rsp_result", rsp_result, shown.res);
        checkOutput("rsp_flags", rsp_flags, shown.fl);
        checkOutput("rsp_z", rsp_z, shown.z);
        checkOutput("rsp_err", rsp_err, shown.err);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic [3:0] op0, input logic f0,
                                 input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                                 input logic [3:0] op1, input logic f1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; req0_flagin = f0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; req1_flagin = f1;
        rsp_ready  = rr;
    endtask

    task automatic drain();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) step();
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic         ids[4];
    logic [W-1:0] res[4];
    logic         zs[4];
    int           n;
    logic [W-1:0] held_res;
    logic         held_id;

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset alu_control", alu_control, 0);
        checkOutput("reset rsp_err", rsp_err, 0);
        step();
        step();
        rst_n = 1'b1;

        // Test 1: single legal add from requester 0.
        applyStimulus(1, 4'b0110, 4'b0010, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("t1 req0_ready", req0_ready, 1);
        checkOutput("t1 req1_ready", req1_ready, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 rsp_valid exec", rsp_valid, 0);
        step();
        checkOutput("t1 rsp_valid", rsp_valid, 1);
        checkOutput("t1 rsp_id", rsp_id, 0);
        checkOutput("t1 rsp_result", rsp_result, 4'b1000);
        checkOutput("t1 rsp_z", rsp_z, 0);
        checkOutput("t1 rsp_err", rsp_err, 0);
        drain();

        // Test 2: both requesters continuously valid from reset.
        do_reset();
        applyStimulus(1, 4'b0110, 4'b0010, 4'h1, 0, 1, 4'b0010, 4'b0010, 4'h1, 0, 1);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            step();
            if (rsp_valid) begin
                ids[n] = rsp_id; res[n] = rsp_result; zs[n] = rsp_z;
                n++;
            end
        end
        checkOutput("t2 response count", n, 4);
        for (int i = 0; i < n; i++) checkOutput("t2 alternating id", ids[i], i % 2);
        if (n >= 2) begin
            checkOutput("t2 first result", res[0], 4'b0100);
            checkOutput("t2 first z", zs[0], 0);
            checkOutput("t2 second result", res[1], 4'b0000);
            checkOutput("t2 second z", zs[1], 1);
        end
        drain();

        // Test 3: illegal opcode from requester 1.
        applyStimulus(0, 0, 0, 0, 0, 1, 4'b0101, 4'b0011, 4'hC, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 rsp_valid", rsp_valid, 1);
        checkOutput("t3 rsp_err", rsp_err, 1);
        checkOutput("t3 rsp_result", rsp_result, 0);
        checkOutput("t3 rsp_id", rsp_id, 1);
        checkOutput("t3 alu_control", alu_control, 4'hC);
        step();
        checkOutput("t3 rsp_valid held", rsp_valid, 1);
        drain();

        // Test 4: response backpressure with both requesters waiting.
        applyStimulus(1, 4'b0110, 4'b0011, 4'h2, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("t4 rsp_valid", rsp_valid, 1);
        checkOutput("t4 rsp_result", rsp_result, 4'b0010);
        held_res = rsp_result;
        held_id  = rsp_id;
        applyStimulus(1, 4'b0001, 4'b0001, 4'h0, 0, 1, 4'b0010, 4'b0010, 4'h1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("t4 held valid", rsp_valid, 1);
            checkOutput("t4 held result", rsp_result, held_res);
            checkOutput("t4 held id", rsp_id, held_id);
            checkOutput("t4 req0_ready low", req0_ready, 0);
            checkOutput("t4 req1_ready low", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        checkOutput("t4 released valid", rsp_valid, 0);
        checkOutput("t4 req1 granted", req1_ready, 1);
        checkOutput("t4 req0 not granted", req0_ready, 0);
        step();
        checkOutput("t4 ready drops in exec", req1_ready, 0);
        drain();

        // Test 5: reset while executing.
        applyStimulus(1, 4'b0001, 4'b0010, 4'h8, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5 rsp_valid", rsp_valid, 0);
        checkOutput("t5 alu_a", alu_a, 0);
        checkOutput("t5 alu_b", alu_b, 0);
        checkOutput("t5 alu_control", alu_control, 0);
        step();
        checkOutput("t5 no response", rsp_valid, 0);
        rst_n = 1'b1;
        applyStimulus(1, 4'b0011, 4'b0001, 4'h0, 0, 1, 4'b0001, 4'b0001, 4'h0, 0, 1);
        #1 checkOutput("t5 req0 wins tie", req0_ready, 1);
        checkOutput("t5 req1 loses tie", req1_ready, 0);
        drain();

        // Test 6: a one-cycle valid pulse during RESP is ignored.
        applyStimulus(1, 4'b0011, 4'b0011, 4'h4, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("t6 rsp_valid", rsp_valid, 1);
        applyStimulus(1, 4'b0111, 4'b0111, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("t6 pulse not ready", req0_ready, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        for (int c = 0; c < 4; c++) begin
            checkOutput("t6 no response", rsp_valid, 0);
            step();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step();
            rst_n = ($urandom_range(0, 299) != 0);
            applyStimulus($urandom_range(0, 9) < 6, W'($urandom), W'($urandom), 4'($urandom), 1'($urandom),
                          $urandom_range(0, 9) < 6, W'($urandom), W'($urandom), 4'($urandom), 1'($urandom),
                          $urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
